sram_mem_ctrl: RTL
==================

Name: sram_mem_ctrl

Overview:
- Parametrised memory-stage controller; replaces the single-cycle data memory between the EXE/MEM pipeline register and the MEM/WB pipeline register.
- Translates byte addresses from the ALU into word addresses for an external SRAM with a configurable number of wait states.
- Drives `ready` low while an access is in flight. The CPU top ORs `~ready` into the global freeze that stalls every pipeline stage.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 32, CPU byte-address width
- SRAM_ADDR_W, 16, SRAM word-address width
- WAIT_CYCLES, 4, SRAM access wait states; legal range 1..15
- BASE_ADDR, 1024, byte address that maps to SRAM word 0
- WORD_BYTES, 4, bytes per word; power of two

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- rd_en  input  1  MEM-stage read request; held until ready
- wr_en  input  1  MEM-stage write request; held until ready
- addr  input  ADDR_W  byte address from the ALU result
- wr_data  input  DATA_W  store data (forwarded Rm value)
- rd_data  output  DATA_W  last completed read word (registered)
- ready  output  1  high = MEM stage may advance this cycle
- addr_err  output  1  one-cycle pulse: access outside the SRAM window
- sram_addr  output  SRAM_ADDR_W  SRAM word address (registered)
- sram_wdata  output  DATA_W  SRAM write data (registered)
- sram_rdata  input  DATA_W  SRAM read data
- sram_we_n  output  1  SRAM write strobe, active low

Behaviour:
- FSM states: IDLE, ACCESS, DONE. A wait counter `wcnt` is 4 bits wide.
- Reset (asynchronous, any state): state=IDLE, wcnt=0, rd_data=0, sram_addr=0, sram_wdata=0, sram_we_n=1, addr_err=0.
- Address translation: `off = addr - BASE_ADDR` computed in ADDR_W bits; `word = off >> log2(WORD_BYTES)`.
- Window check: the access is out of window if `addr < BASE_ADDR`, or `word >= 2**SRAM_ADDR_W`, or the low log2(WORD_BYTES) bits of `off` are nonzero (misaligned).
- `req = rd_en | wr_en`. If both are high, the access is treated as a write.
- IDLE with req and in window:
  - latch sram_addr=word[SRAM_ADDR_W-1:0] and sram_wdata=wr_data;
  - latch op (write/read) internally;
  - wcnt=WAIT_CYCLES-1; go to ACCESS.
- IDLE with req and out of window:
  - pulse addr_err for one cycle; go to DONE;
  - no SRAM strobe; rd_data is unchanged.
- IDLE without req: stay in IDLE.
- ACCESS:
  - sram_we_n=0 for every ACCESS cycle of a write, otherwise 1;
  - wcnt decrements each cycle;
  - when wcnt==0: for a read, capture sram_rdata into rd_data; go to DONE.
- DONE: sram_we_n=1; unconditionally go to IDLE next cycle.
- ready is combinational: `ready = ~req | (state==DONE)`. It is never low when there is no request.
- Latency: a request first seen in IDLE at cycle 0 is in ACCESS for cycles 1..WAIT_CYCLES, reaches DONE at cycle WAIT_CYCLES+1 (ready=1), and returns to IDLE at WAIT_CYCLES+2. The MEM stage is stalled for WAIT_CYCLES+1 cycles.
- Back-to-back accesses: the request presented in the cycle after DONE is a new access. There is one idle-state cycle between accesses, with ready=0 in that cycle.
- Request dropped mid-access (e.g. flush): the access still completes and the FSM walks through DONE. A read still updates rd_data; a write still commits.
- Reset mid-ACCESS: the write strobe is released immediately (asynchronously), and no rd_data update occurs.
- Request inputs are required to be stable from IDLE acceptance until DONE. The controller uses only the values latched at acceptance.

Decomposition:
- Shared package `mem_pkg`:
  - the FSM state enum (IDLE / ACCESS / DONE);
  - the `clog2`-based constant for the WORD_BYTES shift;
  - the default BASE_ADDR.
- One natural sub-module: `mem_addr_xlate`, the combinational offset, shift and window check, producing word and in_window. It is reused later by a cache front-end.

Test Plan:
- Read, in window: WAIT_CYCLES=4, sram model returns 0xDEADBEEF for word 3; rd_en=1, addr=1036 → ready=0 for 5 cycles, sram_addr=3, ready=1 at cycle 5, rd_data=0xDEADBEEF, sram_we_n never low.
- Write: wr_en=1, addr=1024, wr_data=0x12345678 → sram_we_n=0 for exactly 4 cycles, sram_addr=0, sram_wdata=0x12345678, ready=1 at cycle 5; a subsequent read of 1024 returns 0x12345678.
- Out of window / misaligned: rd_en=1, addr=1000 → addr_err pulse at cycle 1 and ready=1 at cycle 1, rd_data unchanged. Repeat with addr=1026 → same response.
- Back-to-back: read at 1028 held, then write at 1032 immediately after → second access accepted on the cycle after DONE; ready pattern 0000010000 01.
- Simultaneous and reset: rd_en=wr_en=1 → write performed. Assert rst during the third ACCESS cycle of a write → sram_we_n=1 within the same cycle, state IDLE, rd_data=0.
- No request: rd_en=wr_en=0 for 20 cycles → ready=1 throughout, sram_we_n=1, state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage controller and its address translator.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam int DEF_BASE_ADDR  = 1024;
    localparam int DEF_WORD_BYTES = 4;

    // Byte-to-word shift amount; WORD_BYTES is always a power of two.
    function automatic int word_shift(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

    localparam int DEF_WORD_SHIFT = word_shift(DEF_WORD_BYTES);

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte address to SRAM word address translation with window and alignment check.
module mem_addr_xlate
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 16,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WORD_BYTES  = DEF_WORD_BYTES
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [SRAM_ADDR_W-1:0] word,
    output logic                   in_window
);

    localparam int                SHIFT = word_shift(WORD_BYTES);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word_full;
    logic              below;
    logic              misaligned;
    logic              too_high;

    assign off       = addr - BASE;
    assign word_full = off >> SHIFT;
    assign below     = (addr < BASE);
    assign word      = SRAM_ADDR_W'(word_full);

    generate
        if (SHIFT > 0) begin : g_align
            assign misaligned = |off[SHIFT-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end

        // Any word bit above the SRAM address range means the access overruns the window.
        if (SRAM_ADDR_W < ADDR_W) begin : g_range
            assign too_high = |word_full[ADDR_W-1:SRAM_ADDR_W];
        end else begin : g_no_range
            assign too_high = 1'b0;
        end
    endgenerate

    assign in_window = ~(below | misaligned | too_high);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: runs a fixed-wait-state SRAM access and stalls the pipeline via ready.
module sram_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 16,
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WORD_BYTES  = DEF_WORD_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   ready,
    output logic                   addr_err,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic [DATA_W-1:0]      sram_rdata,
    output logic                   sram_we_n
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                 state;
    logic [3:0]             wcnt;
    logic                   op_write;
    logic                   req;
    logic                   in_window;
    logic [SRAM_ADDR_W-1:0] word;

    mem_addr_xlate #(
        .ADDR_W      (ADDR_W),
        .SRAM_ADDR_W (SRAM_ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .WORD_BYTES  (WORD_BYTES)
    ) u_xlate (
        .addr      (addr),
        .word      (word),
        .in_window (in_window)
    );

    assign req = rd_en | wr_en;

    // NOTE: ready is combinational on the request so an idle controller never freezes the pipeline.
    assign ready = ~req | (state == DONE);

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            op_write   <= 1'b0;
            rd_data    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (in_window) begin
                            sram_addr  <= word;
                            sram_wdata <= wr_data;
                            op_write   <= wr_en;
                            sram_we_n  <= ~wr_en;
                            wcnt       <= WAIT_INIT;
                            state      <= ACCESS;
                        end else begin
                            addr_err <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (wcnt == 4'd0) begin
                        if (!op_write) begin
                            rd_data <= sram_rdata;
                        end
                        sram_we_n <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                DONE: begin
                    sram_we_n <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    sram_we_n <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
